uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Receive-side controller for the MiniUart receiver. It generates the 8x-oversample enable `en_rx` from a programmable divisor and drains received bytes from the receiver through its `rs`/`over_read` handshake. Bytes are buffered in a small FIFO that the CPU reads through a status/data interface. The block sits between the receiver and the CPU bus bridge; it contains no serial logic itself.

## Interface
- `DIV_W`, 16: divisor width.
- `DIV_RST`, 16'd0: divisor value after reset.
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `clk` in 1: single clock for the block and the receiver.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_en` in 1: receive enable (level).
- `div_we` in 1: divisor write strobe.
- `div_wdata` in DIV_W: new divisor.
- `en_rx` out 1: oversample enable to the receiver.
- `rx_data` in 8: receiver byte output.
- `rx_rs` in 1: receiver byte-available flag (level).
- `over_read` out 1: one-cycle pulse that clears `rx_rs`.
- `cpu_rd` in 1: pop strobe.
- `cpu_data` out 8: FIFO head.
- `rx_avail` out 1: FIFO not empty.
- `rx_full` out 1: FIFO full.
- `rx_count` out $clog2(DEPTH)+1: occupancy.
- `ovr` out 1: sticky overrun flag.
- `ovr_clr` in 1: clears `ovr`.
- `irq_en` in 1: interrupt enable.
- `irq` out 1: registered interrupt.

## Operation
- **Tick generator**
  - Down-counter `tcnt`. When `cfg_en`=1 and `tcnt`=0: `en_rx`=1 for that cycle and `tcnt` reloads the divisor. Otherwise `tcnt` decrements.
  - Period is divisor+1 cycles. Divisor 0 gives `en_rx` every cycle.
  - When `cfg_en`=0: `en_rx`=0 and `tcnt` is held at the divisor.
  - `div_we` loads the divisor register and forces `tcnt` to `div_wdata` on the same edge, which restarts the period. `div_we` takes priority over a normal reload.
- **Drain FSM** (states IDLE, CAPT, ACK, WCLR)
  - IDLE: when `rx_rs`=1, go to CAPT.
  - CAPT: push `rx_data` if the FIFO is not full, or if it is full and `cpu_rd` is active in the same cycle. Otherwise drop the byte and set `ovr`. Go to ACK.
  - ACK: `over_read`=1. Go to WCLR.
  - WCLR: wait for `rx_rs`=0, then go to IDLE. This guarantees one pop per received byte.
  - The drain FSM runs regardless of `cfg_en`, so a byte already flagged is still collected.
- **FIFO**
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave `rx_count` unchanged.
  - `cpu_rd` on an empty FIFO is ignored.
  - `cpu_data` shows the head entry and is 0 when empty.
- **Overrun**
  - `ovr` is set on a dropped byte and cleared by `ovr_clr`.
  - If set and clear occur in the same cycle, set wins.
- **Interrupt**: `irq` is registered as `irq_en & (rx_avail | ovr)`.

## Timing
- Reset values:
  - `en_rx`=0, `over_read`=0, `irq`=0, `ovr`=0.
  - `rx_count`=0, `rx_avail`=0, `rx_full`=0, `cpu_data`=0.
  - FSM in IDLE, divisor=DIV_RST, `tcnt`=DIV_RST.
- `rx_rs` sampled high at edge k:
  - edge k+1: FSM enters CAPT.
  - edge k+2: push; `rx_count`/`rx_avail` update and the FSM enters ACK.
  - cycle after k+2: `over_read`=1.
  - `irq` follows `rx_avail`/`ovr` one cycle later.
- Minimum spacing between captures: 4 cycles.
- `cpu_rd` at edge j: `rx_count` decrements at j and `cpu_data` shows the next entry after j.
- First `en_rx` after `cfg_en` rises: the cycle in which `cfg_en`=1 and `tcnt`=0.
- Reset mid-transfer, including during ACK: all state returns to reset values immediately, and `over_read` drops asynchronously.

## Structure
- Package `uart_pkg`:
  - drain-state enum (IDLE/CAPT/ACK/WCLR)
  - `DIV_W` default
  - `UART_OVS`=8 constant
- Sub-module `uart_rx_fifo`: synchronous FIFO with the DEPTH parameter and push/pop/count/full/empty.
- The tick generator, drain FSM and overrun/interrupt logic stay in the top module.

## Test plan
- Divisor 3, `cfg_en`=1 -> `en_rx` pulses every 4 cycles. Write divisor 1 mid-period -> next pulse 2 cycles after the write, then every 2 cycles.
- `rx_rs` high with `rx_data`=0xA5 -> `over_read` is a single pulse 3 cycles later, `rx_count`=1, `cpu_data`=0xA5. `cpu_rd` -> `rx_count`=0, `cpu_data`=0.
- Push 0x11, 0x22, 0x33, 0x44 (DEPTH=4), then 0x55 -> `rx_full`=1, `ovr`=1, 0x55 dropped. Pops return 0x11..0x44 in order.
- FIFO full and `cpu_rd` coincides with CAPT of 0x66 -> `ovr` stays 0, `rx_count` stays 4, last pop returns 0x66.
- `ovr_clr` and an overrun in the same cycle -> `ovr`=1. With `irq_en`=1, `irq` asserts 1 cycle after `rx_avail` rises.
- Assert `rst_n`=0 during ACK -> `over_read`=0 and `rx_count`=0 immediately. After release, `en_rx` stays 0 until `cfg_en`=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the MiniUart receive path.
package uart_pkg;

   localparam int UART_DIV_W = 16;
   localparam int UART_OVS   = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CAPT = 2'd1,
      ACK  = 2'd2,
      WCLR = 2'd3
   } drain_st_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO, registered pointers; head is combinational (0 when empty).
// Push while full is only accepted together with a pop; pop when empty is ignored.
module uart_rx_fifo #(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [7:0]    push_dat,
   input  logic          pop,
   output logic [7:0]    head_dat,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          push_ok, pop_ok;

   always_comb begin
      empty    = (cnt_q == '0);
      full     = (cnt_q == CW'(DEPTH));
      pop_ok   = pop && !empty;
      push_ok  = push && (!full || pop_ok);
      wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok && !pop_ok) begin
         cnt_d = cnt_q + CW'(1);
      end else if (!push_ok && pop_ok) begin
         cnt_d = cnt_q - CW'(1);
      end
      head_dat = empty ? 8'd0 : mem_q[rd_ptr_q];
      count    = cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: head is masked to 0 while empty.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_dat;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive controller: oversample tick generator, rs/over_read drain FSM, byte FIFO, overrun and irq.
// Byte pushed 2 edges after rx_rs is registered; a full FIFO drops the byte (sets ovr) unless popped that cycle.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int               DIV_W   = UART_DIV_W,
   parameter logic [DIV_W-1:0] DIV_RST = '0,
   parameter int               DEPTH   = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cfg_en,
   input  logic                   div_we,
   input  logic [DIV_W-1:0]       div_wdata,
   output logic                   en_rx,
   input  logic [7:0]             rx_data,
   input  logic                   rx_rs,
   output logic                   over_read,
   input  logic                   cpu_rd,
   output logic [7:0]             cpu_data,
   output logic                   rx_avail,
   output logic                   rx_full,
   output logic [$clog2(DEPTH):0] rx_count,
   output logic                   ovr,
   input  logic                   ovr_clr,
   input  logic                   irq_en,
   output logic                   irq
);

   logic [DIV_W-1:0] div_q, div_d, tcnt_q, tcnt_d;
   drain_st_e        state_q, state_d;
   logic             rs_q, rs_d;
   logic             ovr_q, ovr_d, irq_q, irq_d;
   logic             fifo_push, fifo_full, fifo_empty, drop;

   assign en_rx = cfg_en && (tcnt_q == '0);

   // A divisor write restarts the period from the new value.
   always_comb begin
      div_d = div_we ? div_wdata : div_q;
      if (div_we) begin
         tcnt_d = div_wdata;
      end else if (!cfg_en || tcnt_q == '0) begin
         tcnt_d = div_q;
      end else begin
         tcnt_d = tcnt_q - DIV_W'(1);
      end
   end

   always_comb begin
      state_d   = state_q;
      fifo_push = 1'b0;
      drop      = 1'b0;
      over_read = 1'b0;
      rs_d      = rx_rs;
      case (state_q)
         IDLE: if (rs_q) state_d = CAPT;
         CAPT: begin
            if (!fifo_full || cpu_rd) begin
               fifo_push = 1'b1;
            end else begin
               drop = 1'b1;
            end
            state_d = ACK;
         end
         ACK: begin
            over_read = 1'b1;
            state_d   = WCLR;
         end
         WCLR: if (!rs_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ovr_d = drop | (ovr_q & ~ovr_clr);
      irq_d = irq_en & (rx_avail | ovr_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q   <= DIV_RST;
         tcnt_q  <= DIV_RST;
         state_q <= IDLE;
         rs_q    <= 1'b0;
         ovr_q   <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         div_q   <= div_d;
         tcnt_q  <= tcnt_d;
         state_q <= state_d;
         rs_q    <= rs_d;
         ovr_q   <= ovr_d;
         irq_q   <= irq_d;
      end
   end

   assign ovr      = ovr_q;
   assign irq      = irq_q;
   assign rx_avail = !fifo_empty;
   assign rx_full  = fifo_full;

   uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (fifo_push),
      .push_dat (rx_data),
      .pop      (cpu_rd),
      .head_dat (cpu_data),
      .count    (rx_count),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_uart_rx_ctrl;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_en = 1'b0;
   logic        div_we = 1'b0;
   logic [15:0] div_wdata = '0;
   logic        en_rx;
   logic [7:0]  rx_data = '0;
   logic        rx_rs = 1'b0;
   logic        over_read;
   logic        cpu_rd = 1'b0;
   logic [7:0]  cpu_data;
   logic        rx_avail, rx_full;
   logic [2:0]  rx_count;
   logic        ovr;
   logic        ovr_clr = 1'b0;
   logic        irq_en = 1'b0;
   logic        irq;

   uart_rx_ctrl #(.DIV_W(16), .DIV_RST(16'd0), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_en    (cfg_en),
      .div_we    (div_we),
      .div_wdata (div_wdata),
      .en_rx     (en_rx),
      .rx_data   (rx_data),
      .rx_rs     (rx_rs),
      .over_read (over_read),
      .cpu_rd    (cpu_rd),
      .cpu_data  (cpu_data),
      .rx_avail  (rx_avail),
      .rx_full   (rx_full),
      .rx_count  (rx_count),
      .ovr       (ovr),
      .ovr_clr   (ovr_clr),
      .irq_en    (irq_en),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: cycles since the last tick restart, age of the byte being
   // collected (edges since rx_rs was first seen high), and the FIFO contents as a queue.
   int           m_div = 0;
   int           m_since = 0;
   int           m_age = -1;
   bit           m_rs_prev = 1'b0;
   bit           m_ovr = 1'b0;
   bit           m_irq = 1'b0;
   byte unsigned m_q[$];
   byte unsigned m_tmp;
   bit           m_en, m_pop, m_drop;
   int           m_sz;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_div = 0; m_since = 0; m_age = -1; m_rs_prev = 1'b0;
         m_ovr = 1'b0; m_irq = 1'b0; m_q.delete();
      end else begin
         m_en   = cfg_en && (m_since == m_div);
         m_sz   = m_q.size();
         m_pop  = cpu_rd && (m_sz > 0);
         m_irq  = irq_en && (m_sz > 0 || m_ovr);
         m_drop = 1'b0;
         if (m_age >= 0) m_age++;
         if (m_age > 3) m_age = -1;
         if (m_pop) m_tmp = m_q.pop_front();
         if (m_age == 2) begin
            if (m_sz < DEPTH || m_pop) m_q.push_back(rx_data);
            else m_drop = 1'b1;
         end
         m_ovr = m_drop ? 1'b1 : (ovr_clr ? 1'b0 : m_ovr);
         if (div_we) begin
            m_div   = int'(div_wdata);
            m_since = 0;
         end else if (!cfg_en || m_en) begin
            m_since = 0;
         end else begin
            m_since++;
         end
         if (m_age < 0 && rx_rs && !m_rs_prev) m_age = 0;
         m_rs_prev = rx_rs;
      end
   end

   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         chk("en_rx",     en_rx,     cfg_en && (m_since == m_div));
         chk("over_read", over_read, m_age == 2);
         chk("rx_count",  rx_count,  m_q.size());
         chk("rx_avail",  rx_avail,  m_q.size() > 0);
         chk("rx_full",   rx_full,   m_q.size() == DEPTH);
         chk("cpu_data",  cpu_data,  (m_q.size() > 0) ? m_q[0] : 8'd0);
         chk("ovr",       ovr,       m_ovr);
         chk("irq",       irq,       m_irq);
      end
   end

   // Receiver stand-in: rx_rs drops on the edge that sees over_read.
   task automatic tick();
      logic o;
      o = over_read;
      @(posedge clk);
      #1;
      if (o) rx_rs = 1'b0;
   endtask

   task automatic wait_clear();
      int n;
      n = 0;
      while (rx_rs && n < 20) begin
         tick();
         n++;
      end
      chk("rs_cleared", rx_rs, 1'b0);
      tick();
      tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_rs   = 1'b1;
      wait_clear();
   endtask

   task automatic pop_expect(input string name, input logic [7:0] b);
      chk(name, cpu_data, b);
      cpu_rd = 1'b1;
      tick();
      cpu_rd = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   int n;
   int idle_n;
   int pr;
   logic [7:0] seq4 [4];

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_en_rx", en_rx, 1'b0);
      chk("rst_over_read", over_read, 1'b0);
      chk("rst_irq", irq, 1'b0);
      chk("rst_ovr", ovr, 1'b0);
      chk("rst_count", rx_count, 3'd0);
      chk("rst_avail", rx_avail, 1'b0);
      chk("rst_full", rx_full, 1'b0);
      chk("rst_cpu_data", cpu_data, 8'd0);
      rst_n = 1'b1;
      tick();

      // Tick generator: divisor 3, then divisor 1 written mid-period.
      div_wdata = 16'd3; div_we = 1'b1;
      tick();
      div_we = 1'b0; cfg_en = 1'b1;
      tick();
      n = 0;
      while (!en_rx && n < 20) begin tick(); n++; end
      chk("first_pulse_wait", n, 2);
      n = 0;
      do begin tick(); n++; end while (!en_rx && n < 20);
      chk("period_div3", n, 4);
      tick();
      div_wdata = 16'd1; div_we = 1'b1;
      tick();
      div_we = 1'b0;
      n = 0;
      while (!en_rx && n < 10) begin tick(); n++; end
      chk("pulse_after_write", n, 1);
      n = 0;
      do begin tick(); n++; end while (!en_rx && n < 20);
      chk("period_div1", n, 2);

      // Single byte 0xA5 and the irq one cycle behind rx_avail.
      irq_en = 1'b1;
      rx_data = 8'hA5; rx_rs = 1'b1;
      tick(); tick();
      chk("a5_no_ack_yet", over_read, 1'b0);
      tick();
      chk("a5_over_read", over_read, 1'b1);
      chk("a5_count", rx_count, 3'd1);
      chk("a5_data", cpu_data, 8'hA5);
      chk("a5_irq_before", irq, 1'b0);
      tick();
      chk("a5_ack_single", over_read, 1'b0);
      chk("a5_irq_after", irq, 1'b1);
      tick(); tick();
      cpu_rd = 1'b1; tick(); cpu_rd = 1'b0;
      chk("a5_pop_count", rx_count, 3'd0);
      chk("a5_pop_data", cpu_data, 8'd0);

      // Fill to DEPTH, fifth byte overruns.
      seq4[0] = 8'h11; seq4[1] = 8'h22; seq4[2] = 8'h33; seq4[3] = 8'h44;
      for (int i = 0; i < 4; i++) send_byte(seq4[i]);
      send_byte(8'h55);
      chk("ovf_full", rx_full, 1'b1);
      chk("ovf_ovr", ovr, 1'b1);
      chk("ovf_count", rx_count, 3'd4);
      for (int i = 0; i < 4; i++) pop_expect("ovf_pop", seq4[i]);
      chk("ovf_empty", rx_avail, 1'b0);
      ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
      chk("ovr_cleared", ovr, 1'b0);

      // Full FIFO with a pop in the capture cycle keeps the byte.
      seq4[0] = 8'h61; seq4[1] = 8'h62; seq4[2] = 8'h63; seq4[3] = 8'h64;
      for (int i = 0; i < 4; i++) send_byte(seq4[i]);
      rx_data = 8'h66; rx_rs = 1'b1;
      tick(); tick();
      cpu_rd = 1'b1; tick(); cpu_rd = 1'b0;
      chk("coin_ovr", ovr, 1'b0);
      chk("coin_count", rx_count, 3'd4);
      wait_clear();

      // Overrun and ovr_clr in the same cycle: set wins.
      rx_data = 8'h77; rx_rs = 1'b1;
      tick(); tick();
      ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
      chk("setclr_ovr", ovr, 1'b1);
      wait_clear();
      pop_expect("coin_pop0", 8'h62);
      pop_expect("coin_pop1", 8'h63);
      pop_expect("coin_pop2", 8'h64);
      pop_expect("coin_pop3", 8'h66);
      ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;

      // Randomized traffic; the model checks every cycle.
      idle_n = 2;
      for (int i = 0; i < 700; i++) begin
         pr      = (i < 350) ? 7 : 1;
         cpu_rd  = ($urandom_range(0, pr) == 0);
         ovr_clr = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 15) == 0) irq_en = ~irq_en;
         div_we    = ($urandom_range(0, 24) == 0);
         div_wdata = 16'($urandom_range(0, 5));
         if ($urandom_range(0, 29) == 0) cfg_en = ~cfg_en;
         if (!rx_rs) idle_n++; else idle_n = 0;
         if (!rx_rs && idle_n >= 2 && $urandom_range(0, 2) == 0) begin
            rx_data = 8'($urandom);
            rx_rs   = 1'b1;
         end
         tick();
      end
      cpu_rd = 1'b0; ovr_clr = 1'b0; div_we = 1'b0;
      if (rx_rs) wait_clear();

      // Reset asserted during ACK.
      cfg_en = 1'b1;
      rx_data = 8'h3C; rx_rs = 1'b1;
      tick(); tick(); tick();
      chk("rst_mid_ack", over_read, 1'b1);
      #2;
      rst_n = 1'b0; cfg_en = 1'b0; rx_rs = 1'b0;
      #1;
      chk("rst_async_over_read", over_read, 1'b0);
      chk("rst_async_count", rx_count, 3'd0);
      chk("rst_async_ovr", ovr, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(); tick();
      chk("post_rst_en_rx", en_rx, 1'b0);
      chk("post_rst_cpu_data", cpu_data, 8'd0);
      cfg_en = 1'b1;
      #1;
      chk("post_rst_first_tick", en_rx, 1'b1);
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
